// File: rtl/ddr_rd_scheduler_if.sv
// ---------------------------------------------------------------------------
// ddr_rd_scheduler_if
//   Bundles every signal between the read scheduler, the convolution-block
//   requesters and the DDR read controller. clk and reset stay plain ports.
//
//   Requester side : rdDS_req, rdDS_Vaddr (in), rdDS_granted,
//                    rdDS_data18bit, rdDS_data18bit_vld (out)
//   DDR side       : ddr_cmd_vld, ddr_cmd_addr, ddr_cmd_len (out),
//                    ddr_cmd_rdy, ddr_rd_data, ddr_rd_vld (in)
//   Status         : busy, spurious_beat (out)
//
//   Handshake: a command transfers on a cycle where ddr_cmd_vld and
//   ddr_cmd_rdy are both high at the rising edge. Once ddr_cmd_vld rises it
//   stays high, with ddr_cmd_addr/ddr_cmd_len unchanged, until that transfer.
//   Read beats carry no back-pressure: every cycle with ddr_rd_vld high is one
//   beat. A requester holds rdDS_req until it sees its rdDS_granted pulse.
//
//   master : the scheduler itself
//   slave  : the environment (requesters + DDR read controller)
// ---------------------------------------------------------------------------
interface ddr_rd_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH_VADDR = 16,
    parameter int WIDTH_PADDR = 28,
    parameter int BURST_LEN   = 224
) ();
    localparam int LEN_W = $clog2(BURST_LEN + 1);

    logic [NUM_REQ-1:0]             rdDS_req;
    logic [NUM_REQ*WIDTH_VADDR-1:0] rdDS_Vaddr;
    logic [NUM_REQ-1:0]             rdDS_granted;
    logic [17:0]                    rdDS_data18bit;
    logic [NUM_REQ-1:0]             rdDS_data18bit_vld;
    logic                           ddr_cmd_vld;
    logic                           ddr_cmd_rdy;
    logic [WIDTH_PADDR-1:0]         ddr_cmd_addr;
    logic [LEN_W-1:0]               ddr_cmd_len;
    logic [17:0]                    ddr_rd_data;
    logic                           ddr_rd_vld;
    logic                           busy;
    logic                           spurious_beat;

    modport master (
        input  rdDS_req, rdDS_Vaddr, ddr_cmd_rdy, ddr_rd_data, ddr_rd_vld,
        output rdDS_granted, rdDS_data18bit, rdDS_data18bit_vld,
               ddr_cmd_vld, ddr_cmd_addr, ddr_cmd_len, busy, spurious_beat
    );

    modport slave (
        output rdDS_req, rdDS_Vaddr, ddr_cmd_rdy, ddr_rd_data, ddr_rd_vld,
        input  rdDS_granted, rdDS_data18bit, rdDS_data18bit_vld,
               ddr_cmd_vld, ddr_cmd_addr, ddr_cmd_len, busy, spurious_beat
    );
endinterface

// File: rtl/ddr_rd_scheduler.sv
// ---------------------------------------------------------------------------
// ddr_rd_scheduler
//   Shares one DDR read channel among NUM_REQ convolution blocks. A
//   round-robin arbiter picks one pending requester, pulses its rdDS_granted
//   bit, issues one read command at i*BASE_STRIDE + Vaddr[i], then forwards
//   the BURST_LEN returning 18-bit beats with a valid bit for the owner only.
//
//   Ports
//     clk       : clock
//     reset     : asynchronous active-low reset (0 = in reset)
//     bus       : ddr_rd_scheduler_if.master (requester + DDR + status)
//     dbg_state : current FSM state (IDLE=0, CMD=1, DATA=2)
// ---------------------------------------------------------------------------
module ddr_rd_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH_VADDR = 16,
    parameter int WIDTH_PADDR = 28,
    parameter int BASE_STRIDE = 2**20,
    parameter int BURST_LEN   = 224
) (
    input  logic                      clk,
    input  logic                      reset,
    ddr_rd_scheduler_if.master        bus,
    output logic [1:0]                dbg_state
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int LEN_W = $clog2(BURST_LEN + 1);
    localparam logic [WIDTH_PADDR-1:0] STRIDE    = WIDTH_PADDR'(BASE_STRIDE);
    localparam logic [LEN_W-1:0]       LAST_BEAT = LEN_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        cand;
    logic                    found;
    logic [WIDTH_PADDR-1:0]  winner_paddr;
    logic [NUM_REQ-1:0]      winner_oh;
    logic [NUM_REQ-1:0]      owner;
    logic [LEN_W-1:0]        beat_cnt;
    logic [NUM_REQ-1:0]      granted;
    logic [NUM_REQ-1:0]      data_vld;
    logic [17:0]             data;
    logic [WIDTH_PADDR-1:0]  cmd_addr;
    logic                    spurious;
    logic                    grant_now;
    logic                    accept;
    logic                    beat_take;

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                cand = PTR_W'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                cand = PTR_W'(int'(rr_ptr) + k);
            end
            if (!found && bus.rdDS_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Zero-extended virtual address plus per-requester base; the sum wraps
    // naturally at WIDTH_PADDR bits.
    always_comb begin
        winner_oh    = NUM_REQ'(1) << winner;
        winner_paddr = WIDTH_PADDR'(winner) * STRIDE
                     + WIDTH_PADDR'(bus.rdDS_Vaddr[int'(winner)*WIDTH_VADDR +: WIDTH_VADDR]);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        accept    = 1'b0;
        beat_take = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_now = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                // ddr_cmd_vld is high for the whole of CMD, so rdy alone
                // completes the handshake.
                if (bus.ddr_cmd_rdy) begin
                    accept    = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.ddr_rd_vld) begin
                    beat_take = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            granted  <= '0;
            cmd_addr <= '0;
            beat_cnt <= '0;
            data_vld <= '0;
            data     <= '0;
            spurious <= 1'b0;
        end else begin
            granted  <= '0;
            data_vld <= '0;
            if (grant_now) begin
                granted  <= winner_oh;
                owner    <= winner_oh;
                cmd_addr <= winner_paddr;
                rr_ptr   <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
            end
            if (accept) begin
                beat_cnt <= '0;
            end
            if (beat_take) begin
                data     <= bus.ddr_rd_data;
                data_vld <= owner;
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
            // Beats outside DATA belong to no burst (e.g. one cut by reset).
            if (bus.ddr_rd_vld && (state != DATA)) begin
                spurious <= 1'b1;
            end
        end
    end

    assign bus.rdDS_granted       = granted;
    assign bus.rdDS_data18bit     = data;
    assign bus.rdDS_data18bit_vld = data_vld;
    assign bus.ddr_cmd_vld        = (state == CMD);
    assign bus.ddr_cmd_addr       = cmd_addr;
    assign bus.ddr_cmd_len        = LEN_W'(BURST_LEN);
    assign bus.busy               = (state != IDLE);
    assign bus.spurious_beat      = spurious;
    assign dbg_state              = state;
endmodule
